// File: rtl/fuzz_harness_pkg.sv
// Shared definitions for the fuzz stimulus / signature harness.
//   state_e        : harness FSM states
//   WIREn_W, Y_W   : port widths of the randomized DUT being exercised
//   DEF_LFSR_TAPS  : default Galois feedback mask for the stimulus LFSR
//   DEF_MISR_POLY  : default feedback mask for the 64-bit signature MISR
package fuzz_harness_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      DRAIN   = 3'd2,
      SEND_LO = 3'd3,
      SEND_HI = 3'd4
   } state_e;

   localparam int WIRE0_W = 14;
   localparam int WIRE1_W = 6;
   localparam int WIRE2_W = 15;
   localparam int WIRE3_W = 18;
   localparam int STIM_W  = WIRE3_W + WIRE2_W + WIRE1_W + WIRE0_W;
   localparam int Y_W     = 594;

   localparam logic [63:0] DEF_LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [63:0] DEF_MISR_POLY = 64'h0000_0000_0000_001B;

endpackage

// File: rtl/sig_misr.sv
// Folds the DUT y vector to 64 bits and absorbs it into a 64-bit MISR.
//   clk, rst_n : clock, synchronous active-low reset (signature -> 0)
//   clr        : clear the signature (wins over en)
//   en         : absorb y_in this cycle
//   y_in       : DUT output vector
//   sig        : current signature
//   sig_next   : value the signature takes at the next edge
module sig_misr #(
   parameter int          Y_W  = fuzz_harness_pkg::Y_W,
   parameter logic [63:0] POLY = fuzz_harness_pkg::DEF_MISR_POLY
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           en,
   input  logic [Y_W-1:0] y_in,
   output logic [63:0]    sig,
   output logic [63:0]    sig_next
);
   import fuzz_harness_pkg::*;

   localparam int CHUNKS = (Y_W + 63) / 64;

   logic [CHUNKS*64-1:0] y_pad;
   logic [63:0]          fold;
   logic [63:0]          sig_d;
   logic [63:0]          sig_q;

   // Zero-pad y to whole 64-bit chunks and XOR the chunks together.
   always_comb begin
      y_pad = '0;
      y_pad[Y_W-1:0] = y_in;
      fold = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         fold = fold ^ y_pad[k*64 +: 64];
      end
   end

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[62:0], 1'b0} ^ (sig_q[63] ? POLY : 64'h0) ^ fold;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig      = sig_q;
   assign sig_next = sig_d;

endmodule

// File: rtl/fuzz_stim_sig_harness.sv
// Stimulus/signature harness: drives a randomized DUT from an LFSR for
// RUN_CYCLES cycles, compacts its y output into a MISR (plus DRAIN_CYCLES
// extra captures with stimulus frozen), then streams the 64-bit signature
// as two 32-bit words, low word first.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin a run (only looked at in IDLE)
//   y_in        : DUT output vector
//   stim_out    : {wire3, wire2, wire1, wire0} to the DUT
//   sig_data    : signature word; sig_last marks the high (final) word
//   sig_valid / sig_ready : valid/ready handshake. A word transfers on a
//                 cycle where both are high. While valid is high and ready
//                 low, data and last hold; valid only drops after a transfer;
//                 ready is ignored while valid is low.
//   busy        : FSM not in IDLE
//   done        : one-cycle pulse after the final word is accepted
module fuzz_stim_sig_harness #(
   parameter int          Y_W          = fuzz_harness_pkg::Y_W,
   parameter int          STIM_W       = fuzz_harness_pkg::STIM_W,
   parameter int          SIG_W        = 64,
   parameter int          RUN_CYCLES   = 1024,
   parameter int          DRAIN_CYCLES = 1,
   parameter logic [63:0] SEED         = 64'h0123_4567_89AB_CDEF,
   parameter logic [63:0] LFSR_TAPS    = fuzz_harness_pkg::DEF_LFSR_TAPS,
   parameter logic [63:0] MISR_POLY    = fuzz_harness_pkg::DEF_MISR_POLY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [Y_W-1:0]    y_in,
   output logic [STIM_W-1:0] stim_out,
   output logic [31:0]       sig_data,
   output logic              sig_valid,
   input  logic              sig_ready,
   output logic              sig_last,
   output logic              busy,
   output logic              done
);
   import fuzz_harness_pkg::*;

   localparam int CNT_MAX = (RUN_CYCLES > DRAIN_CYCLES) ? RUN_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   state_e           state_q, state_d;
   logic [63:0]      lfsr_q, lfsr_d, lfsr_step;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sig_data_q, sig_data_d;
   logic             sig_valid_q, sig_valid_d;
   logic             sig_last_q, sig_last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             misr_clr, misr_en;
   logic [SIG_W-1:0] sig, sig_next;

   sig_misr #(
      .Y_W  (Y_W),
      .POLY (MISR_POLY)
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (misr_clr),
      .en       (misr_en),
      .y_in     (y_in),
      .sig      (sig),
      .sig_next (sig_next)
   );

   assign lfsr_step = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      cnt_d       = cnt_q;
      sig_data_d  = sig_data_q;
      sig_valid_d = sig_valid_q;
      sig_last_d  = sig_last_q;
      done_d      = 1'b0;
      misr_clr    = 1'b0;
      misr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               lfsr_d   = SEED;
               cnt_d    = '0;
               misr_clr = 1'b1;
            end
         end
         RUN: begin
            misr_en = 1'b1;
            lfsr_d  = lfsr_step;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == RUN_LAST) begin
               cnt_d = '0;
               if (DRAIN_CYCLES > 0) begin
                  state_d = DRAIN;
               end else begin
                  // sig_next already includes the final sample.
                  state_d     = SEND_LO;
                  sig_valid_d = 1'b1;
                  sig_last_d  = 1'b0;
                  sig_data_d  = sig_next[31:0];
               end
            end
         end
         DRAIN: begin
            misr_en = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == DRAIN_LAST) begin
               cnt_d       = '0;
               state_d     = SEND_LO;
               sig_valid_d = 1'b1;
               sig_last_d  = 1'b0;
               sig_data_d  = sig_next[31:0];
            end
         end
         SEND_LO: begin
            if (sig_ready) begin
               state_d    = SEND_HI;
               sig_data_d = sig[63:32];
               sig_last_d = 1'b1;
            end
         end
         SEND_HI: begin
            if (sig_ready) begin
               state_d     = IDLE;
               sig_valid_d = 1'b0;
               sig_last_d  = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         cnt_q       <= '0;
         sig_data_q  <= '0;
         sig_valid_q <= 1'b0;
         sig_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         sig_data_q  <= sig_data_d;
         sig_valid_q <= sig_valid_d;
         sig_last_q  <= sig_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign stim_out  = lfsr_q[STIM_W-1:0];
   assign sig_data  = sig_data_q;
   assign sig_valid = sig_valid_q;
   assign sig_last  = sig_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fuzz_stim_sig_harness.sv
// Bench for fuzz_stim_sig_harness: two instances (short run without drain,
// longer run with drain and a small seed), a vector table of runs with
// backpressure / start-glitch options, randomized y stimulus scored against
// a signature model built from the LFSR/fold/MISR rules, and hand-written
// reset sequences.
module tb_fuzz_stim_sig_harness;

   localparam int          YW      = 594;
   localparam logic [63:0] TAPS    = 64'hD800_0000_0000_0000;
   localparam logic [63:0] POLY    = 64'h0000_0000_0000_001B;
   localparam logic [63:0] SEED_A  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] SEED_B  = 64'h0000_0000_0000_0002;
   localparam int          RUN_A   = 4;
   localparam int          DRN_A   = 0;
   localparam int          RUN_B   = 16;
   localparam int          DRN_B   = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start_v [2];
   logic [YW-1:0] y_v     [2];
   logic          ready_v [2];
   logic [52:0]   stim_v  [2];
   logic [31:0]   data_v  [2];
   logic          valid_v [2];
   logic          last_v  [2];
   logic          busy_v  [2];
   logic          done_v  [2];

   fuzz_stim_sig_harness #(
      .RUN_CYCLES (RUN_A), .DRAIN_CYCLES (DRN_A), .SEED (SEED_A)
   ) u_dut_a (
      .clk (clk), .rst_n (rst_n), .start (start_v[0]), .y_in (y_v[0]),
      .stim_out (stim_v[0]), .sig_data (data_v[0]), .sig_valid (valid_v[0]),
      .sig_ready (ready_v[0]), .sig_last (last_v[0]), .busy (busy_v[0]),
      .done (done_v[0])
   );

   fuzz_stim_sig_harness #(
      .RUN_CYCLES (RUN_B), .DRAIN_CYCLES (DRN_B), .SEED (SEED_B)
   ) u_dut_b (
      .clk (clk), .rst_n (rst_n), .start (start_v[1]), .y_in (y_v[1]),
      .stim_out (stim_v[1]), .sig_data (data_v[1]), .sig_valid (valid_v[1]),
      .sig_ready (ready_v[1]), .sig_last (last_v[1]), .busy (busy_v[1]),
      .done (done_v[1])
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int run_of(input int d);
      return (d == 0) ? RUN_A : RUN_B;
   endfunction
   function automatic int drn_of(input int d);
      return (d == 0) ? DRN_A : DRN_B;
   endfunction
   function automatic logic [63:0] seed_of(input int d);
      return (d == 0) ? SEED_A : SEED_B;
   endfunction

   function automatic logic [63:0] lfsr_next(input logic [63:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : 64'h0);
   endfunction

   function automatic logic [63:0] fold_of(input logic [YW-1:0] y);
      logic [639:0] p;
      logic [63:0]  f;
      p = '0;
      p[YW-1:0] = y;
      f = '0;
      for (int k = 0; k < 10; k++) f = f ^ p[k*64 +: 64];
      return f;
   endfunction

   function automatic logic [63:0] misr_next(input logic [63:0] s, input logic [YW-1:0] y);
      return (s << 1) ^ (s[63] ? POLY : 64'h0) ^ fold_of(y);
   endfunction

   // 0: zeros, 1: constant 1, 2: bit 64 only, 3: dense random, 4: one random bit
   function automatic logic [YW-1:0] rand_y(input int mode);
      logic [639:0]  w;
      logic [YW-1:0] y;
      w = '0;
      y = '0;
      case (mode)
         1: y[0] = 1'b1;
         2: y[64] = 1'b1;
         3: begin
            for (int i = 0; i < 20; i++) w[i*32 +: 32] = $urandom;
            y = w[YW-1:0];
         end
         4: y[$urandom_range(0, YW-1)] = 1'b1;
         default: y = '0;
      endcase
      return y;
   endfunction

   // ---------------- driver tasks ----------------
   // Caller has raised start_v[d] at the current negedge.
   task automatic do_run(input int d, input int mode, input int bp_lo, input int bp_hi,
                         input bit glitch_run, input bit glitch_hi, input bit chain,
                         input bit have_exp, input logic [63:0] exp_sig);
      logic [63:0]   lf;
      logic [63:0]   sg;
      logic [YW-1:0] y;
      int            r;
      int            dr;
      lf = seed_of(d);
      sg = '0;
      r  = run_of(d);
      dr = drn_of(d);
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int i = 0; i < r + dr; i++) begin
         check($sformatf("busy_run d%0d c%0d", d, i), 64'(busy_v[d]), 64'd1);
         check($sformatf("valid_run d%0d c%0d", d, i), 64'(valid_v[d]), 64'd0);
         check($sformatf("stim d%0d c%0d", d, i), 64'(stim_v[d]), 64'(lf[52:0]));
         y = rand_y(mode);
         y_v[d] = y;
         sg = misr_next(sg, y);
         if (i < r) lf = lfsr_next(lf);
         start_v[d] = glitch_run && (i == 1);
         ready_v[d] = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      y_v[d] = rand_y(3);
      if (have_exp) sg = exp_sig;
      exp_q.push_back(sg[31:0]);
      exp_q.push_back(sg[63:32]);
      for (int k = 0; k < bp_lo; k++) begin
         ready_v[d] = 1'b0;
         check($sformatf("valid_lo_hold d%0d", d), 64'(valid_v[d]), 64'd1);
         check($sformatf("last_lo_hold d%0d", d), 64'(last_v[d]), 64'd0);
         check($sformatf("data_lo_hold d%0d", d), 64'(data_v[d]), 64'(exp_q[0]));
         @(negedge clk);
      end
      ready_v[d] = 1'b1;
      check($sformatf("valid_lo d%0d", d), 64'(valid_v[d]), 64'd1);
      check($sformatf("last_lo d%0d", d), 64'(last_v[d]), 64'd0);
      check($sformatf("data_lo d%0d", d), 64'(data_v[d]), 64'(exp_q.pop_front()));
      @(negedge clk);
      for (int k = 0; k < bp_hi; k++) begin
         ready_v[d] = 1'b0;
         start_v[d] = glitch_hi && (k == 0);
         check($sformatf("valid_hi_hold d%0d", d), 64'(valid_v[d]), 64'd1);
         check($sformatf("last_hi_hold d%0d", d), 64'(last_v[d]), 64'd1);
         check($sformatf("data_hi_hold d%0d", d), 64'(data_v[d]), 64'(exp_q[0]));
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
      check($sformatf("valid_hi d%0d", d), 64'(valid_v[d]), 64'd1);
      check($sformatf("last_hi d%0d", d), 64'(last_v[d]), 64'd1);
      check($sformatf("data_hi d%0d", d), 64'(data_v[d]), 64'(exp_q.pop_front()));
      check($sformatf("busy_hi d%0d", d), 64'(busy_v[d]), 64'd1);
      @(negedge clk);
      ready_v[d] = 1'($urandom_range(0, 1));
      check($sformatf("done_pulse d%0d", d), 64'(done_v[d]), 64'd1);
      check($sformatf("busy_after d%0d", d), 64'(busy_v[d]), 64'd0);
      check($sformatf("valid_after d%0d", d), 64'(valid_v[d]), 64'd0);
      if (chain) begin
         start_v[d] = 1'b1;
      end else begin
         @(negedge clk);
         check($sformatf("done_clear d%0d", d), 64'(done_v[d]), 64'd0);
         check($sformatf("busy_idle d%0d", d), 64'(busy_v[d]), 64'd0);
         check($sformatf("valid_idle d%0d", d), 64'(valid_v[d]), 64'd0);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s stim d%0d", tag, d), 64'(stim_v[d]), 64'(seed_of(d) & 64'h001F_FFFF_FFFF_FFFF));
         check($sformatf("%s valid d%0d", tag, d), 64'(valid_v[d]), 64'd0);
         check($sformatf("%s busy d%0d", tag, d), 64'(busy_v[d]), 64'd0);
         check($sformatf("%s done d%0d", tag, d), 64'(done_v[d]), 64'd0);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          d;
      int          mode;
      int          bp_lo;
      int          bp_hi;
      bit          glitch_run;
      bit          glitch_hi;
      bit          chain;
      bit          have_exp;
      logic [63:0] exp_sig;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // run length 4, no drain: zeros -> 0; constant 1 -> 1,3,7,0xF
      tbl[0] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
      tbl[1] = '{0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF};
      tbl[2] = '{0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF};
      // 16 run + 3 drain captures of constant 1 -> 2^19-1
      tbl[3] = '{1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
      tbl[4] = '{1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7_FFFF};
      tbl[5] = '{0, 3, 5, 2, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
      tbl[6] = '{0, 3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
      tbl[7] = '{1, 3, 2, 3, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
      tbl[8] = '{1, 4, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
      tbl[9] = '{0, 4, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};

      for (int d = 0; d < 2; d++) begin
         start_v[d] = 1'b0;
         y_v[d]     = '0;
         ready_v[d] = 1'b0;
      end

      // reset state
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_state("reset");
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset last d%0d", d), 64'(last_v[d]), 64'd0);
         check($sformatf("reset data d%0d", d), 64'(data_v[d]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // reset in the middle of a run (run counter at 10)
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         y_v[1] = rand_y(3);
         @(negedge clk);
      end
      check("midrun busy before reset", 64'(busy_v[1]), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("midrun_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("no word after reset", 64'(valid_v[1]), 64'd0);

      // table
      for (int i = 0; i < 10; i++) begin
         if (i == 0 || !tbl[i-1].chain) start_v[tbl[i].d] = 1'b1;
         do_run(tbl[i].d, tbl[i].mode, tbl[i].bp_lo, tbl[i].bp_hi, tbl[i].glitch_run,
                tbl[i].glitch_hi, tbl[i].chain, tbl[i].have_exp, tbl[i].exp_sig);
      end

      // randomized runs
      for (int n = 0; n < 8; n++) begin
         int d;
         d = $urandom_range(0, 1);
         start_v[d] = 1'b1;
         do_run(d, $urandom_range(3, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 64'h0);
      end

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
